sap_reg_bank: RTL and testbench
===============================

SAP_REG_BANK -- requirements
Module: sap_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of every register, legal values 4..32.
REQ-002 SHALL have parameter DEPTH, default 4: number of registers, power of two, legal values 2..16.
REQ-003 SHALL use derived AW = log2(DEPTH) as the width of every select port.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port clr, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port nL, input, 1: active-low operation strobe; the operation executes when nL=0.
REQ-007 SHALL have port op, input, 3: operation code; 000 LOAD, 001 INC, 010 DEC, 011 CLR, 100 SHL, 101 SHR, 110 and 111 reserved.
REQ-008 SHALL have port wsel, input, AW: target register of the operation.
REQ-009 SHALL have port din, input, WIDTH: LOAD data.
REQ-010 SHALL have port rsel, input, AW: register to read.
REQ-011 SHALL have port nE, input, 1: active-low read enable.
REQ-012 SHALL have port dout, output, WIDTH: registered read data.
REQ-013 SHALL have port dvalid, output, 1: high for exactly the cycle after a cycle with nE=0.
REQ-014 SHALL have port cy, output, 1: registered carry/borrow/shift-out of the last executed operation.
REQ-015 SHALL have port zero, output, 1: registered flag, high when the operation result was zero.

Function
REQ-016 LOAD SHALL write din to reg[wsel].
REQ-017 INC SHALL write reg[wsel]+1 modulo 2^WIDTH; cy=1 only on wrap from all-ones to 0.
REQ-018 DEC SHALL write reg[wsel]-1 modulo 2^WIDTH; cy=1 only on wrap from 0 to all-ones.
REQ-019 CLR SHALL write 0 to reg[wsel] and set cy=0.
REQ-020 LOAD SHALL set cy=0.
REQ-021 Reserved op codes SHALL leave every register unchanged and set cy=0; zero reflects the unchanged reg[wsel].
REQ-022 cy and zero SHALL update only on cycles with nL=0, and SHALL hold otherwise.
REQ-023 The write latency SHALL be 1 cycle: the new value is visible in the register from the next edge.
REQ-024 With nE=0, dout SHALL capture reg[rsel] at the edge, giving 1-cycle read latency.
REQ-025 With nE=1, dout SHALL hold its last value.
REQ-026 When rsel equals wsel with nE=0 and nL=0 in the same cycle, dout SHALL capture the pre-operation value.
REQ-027 Registers not addressed by wsel SHALL never change, except on clr.
REQ-028 Read and operation strobes SHALL be independent; both may be active every cycle, with no throughput limit.

Reset
REQ-029 clr=1 at an edge SHALL set every register, dout, dvalid and cy to 0, and set zero to 1.
REQ-030 clr SHALL take priority over nL and nE in the same cycle; a strobed operation in a clr cycle is discarded.
REQ-031 After clr is released, the first cycle SHALL accept operations and reads normally.

Configuration
REQ-032 Macro SAP_REG_BANK_SHIFT_EN defined: SHL SHALL write {reg[WIDTH-2:0],0} with cy=reg[WIDTH-1], and SHR SHALL write {0,reg[WIDTH-1:1]} with cy=reg[0].
REQ-033 Macro SAP_REG_BANK_SHIFT_EN undefined: codes 100 and 101 SHALL behave as reserved per REQ-021, and no shifter logic SHALL be built.

Verification
REQ-034 clr pulse after random writes -> all reads return 0x00, cy=0, zero=1, dvalid=0.
REQ-035 LOAD 0xA5 into reg2, then nE=0 with rsel=2 -> dout=0xA5 with dvalid=1 one cycle after the read.
REQ-036 LOAD 0xFF into reg1, then INC -> reg1=0x00, cy=1, zero=1; then DEC -> reg1=0xFF, cy=1, zero=0.
REQ-037 Same cycle LOAD 0x3C to reg3 and read reg3 (old value 0x11) -> dout=0x11; a read the next cycle -> 0x3C.
REQ-038 clr and nL=0 LOAD 0x77 in the same cycle -> register stays 0x00.
REQ-039 reg0=0x81 with SHL: macro defined -> 0x02 and cy=1; macro undefined -> 0x81 and cy=0.

Source files
------------

// File: rtl/sap_reg_bank.sv
// SAP register bank: DEPTH x WIDTH registers with strobed ALU ops (LOAD/INC/DEC/CLR)
// and an independent registered read port. Define SAP_REG_BANK_SHIFT_EN to add SHL/SHR.
module sap_reg_bank #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             nL,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    wsel,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    rsel,
  input  logic             nE,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             cy,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_INC  = 3'b001,
    OP_DEC  = 3'b010,
    OP_CLR  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101
  } op_e;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  logic             res_cy;
  logic [WIDTH:0]   ext;

  assign operand = regs[wsel];

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    result = operand;
    res_cy = 1'b0;
    ext    = '0;
    case (op)
      OP_LOAD: result = din;
      OP_INC: begin
        ext    = {1'b0, operand} + (WIDTH+1)'(1);
        result = ext[WIDTH-1:0];
        res_cy = ext[WIDTH];
      end
      OP_DEC: begin
        // Borrow shows up as the extension bit going high on 0 -> all-ones.
        ext    = {1'b0, operand} - (WIDTH+1)'(1);
        result = ext[WIDTH-1:0];
        res_cy = ext[WIDTH];
      end
      OP_CLR: result = '0;
`ifdef SAP_REG_BANK_SHIFT_EN
      OP_SHL: begin
        result = {operand[WIDTH-2:0], 1'b0};
        res_cy = operand[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, operand[WIDTH-1:1]};
        res_cy = operand[0];
      end
`endif
      default: begin
        result = operand;
        res_cy = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; that is what
  // makes a same-cycle read of the target register return the pre-op value.
  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: the register array is cleared on clr because software relies on
      // an all-zero bank after reset; it is small enough to live in flops.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
      cy     <= 1'b0;
      zero   <= 1'b1;
    end else begin
      if (!nL) begin
        regs[wsel] <= result;
        cy         <= res_cy;
        zero       <= (result == '0);
      end
      if (!nE) dout <= regs[rsel];
      dvalid <= ~nE;
    end
  end

endmodule

// File: tb/tb_sap_reg_bank.sv
// Self-checking bench for sap_reg_bank: directed scenarios plus randomized
// traffic against an arithmetic reference model. Honors SAP_REG_BANK_SHIFT_EN.
module tb_sap_reg_bank;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             nL  = 1'b1;
  logic [2:0]       op  = '0;
  logic [AW-1:0]    wsel = '0;
  logic [WIDTH-1:0] din = '0;
  logic [AW-1:0]    rsel = '0;
  logic             nE  = 1'b1;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic             cy;
  logic             zero;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int mem [DEPTH];
  int m_dout = 0;
  bit m_dvalid = 0;
  bit m_cy = 0;
  bit m_zero = 1;

  sap_reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .nL(nL), .op(op), .wsel(wsel), .din(din),
    .rsel(rsel), .nE(nE), .dout(dout), .dvalid(dvalid), .cy(cy), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare all outputs.
  task automatic step(input string tag, input bit c, input bit n_l, input int o,
                      input int ws, input int d, input int rs, input bit n_e);
    int old, res;
    bit c_out;
    clr = c; nL = n_l; op = 3'(o); wsel = AW'(ws); din = WIDTH'(d); rsel = AW'(rs); nE = n_e;
    if (c) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 0;
      m_dout = 0; m_dvalid = 0; m_cy = 0; m_zero = 1;
    end else begin
      if (!n_e) m_dout = mem[rs];
      m_dvalid = !n_e;
      if (!n_l) begin
        old = mem[ws];
        res = old;
        c_out = 0;
        case (o)
          0: res = d % MOD;
          1: begin res = (old + 1) % MOD; c_out = (old == MOD - 1); end
          2: begin res = (old + MOD - 1) % MOD; c_out = (old == 0); end
          3: res = 0;
`ifdef SAP_REG_BANK_SHIFT_EN
          4: begin res = (old * 2) % MOD; c_out = (old >= MOD / 2); end
          5: begin res = old / 2; c_out = (old % 2 == 1); end
`endif
          default: res = old;
        endcase
        mem[ws] = res;
        m_cy = c_out;
        m_zero = (res == 0);
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".dout"},   32'(dout),   32'(m_dout));
    check({tag, ".dvalid"}, 32'(dvalid), 32'(m_dvalid));
    check({tag, ".cy"},     32'(cy),     32'(m_cy));
    check({tag, ".zero"},   32'(zero),   32'(m_zero));
  endtask

  initial begin
    @(negedge clk);
    // Reset state
    step("reset", 1, 1, 0, 0, 0, 0, 1);
    step("post_reset_idle", 0, 1, 0, 0, 0, 0, 1);

    // LOAD 0xA5 into reg2, then read it back
    step("load_a5", 0, 0, 0, 2, 'hA5, 0, 1);
    step("read_a5", 0, 1, 0, 0, 0, 2, 0);
    step("read_a5_hold", 0, 1, 0, 0, 0, 0, 1);

    // INC wrap and DEC wrap on reg1
    step("load_ff", 0, 0, 0, 1, 'hFF, 0, 1);
    step("inc_wrap", 0, 0, 1, 1, 0, 0, 1);
    step("read_inc", 0, 1, 0, 0, 0, 1, 0);
    step("dec_wrap", 0, 0, 2, 1, 0, 0, 1);
    step("read_dec", 0, 1, 0, 0, 0, 1, 0);
    step("flags_hold", 0, 1, 1, 1, 0, 0, 1);

    // Same-cycle write/read returns the pre-op value
    step("load_11", 0, 0, 0, 3, 'h11, 0, 1);
    step("load_3c_rd", 0, 0, 0, 3, 'h3C, 3, 0);
    step("read_3c", 0, 1, 0, 0, 0, 3, 0);

    // clr discards a same-cycle LOAD
    step("clr_load", 1, 0, 0, 2, 'h77, 2, 0);
    step("read_clr", 0, 1, 0, 0, 0, 2, 0);

    // Shift left of 0x81 (behaves as reserved without the shift option)
    step("load_81", 0, 0, 0, 0, 'h81, 0, 1);
    step("shl_81", 0, 0, 4, 0, 0, 0, 1);
    step("read_shl", 0, 1, 0, 0, 0, 0, 0);
    step("shr", 0, 0, 5, 0, 0, 0, 1);
    step("read_shr", 0, 1, 0, 0, 0, 0, 0);

    // Reserved codes and CLR
    step("load_5a", 0, 0, 0, 1, 'h5A, 0, 1);
    step("rsvd_6", 0, 0, 6, 1, 0, 1, 0);
    step("rsvd_7", 0, 0, 7, 1, 0, 1, 0);
    step("clr_op", 0, 0, 3, 1, 0, 1, 0);
    step("read_clr_op", 0, 1, 0, 0, 0, 1, 0);

    // Randomized traffic; occasional clr
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, DEPTH - 1),
           $urandom_range(0, MOD - 1), $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 1));
    end

    // Random writes, then clr, then every register reads back zero
    for (int i = 0; i < DEPTH; i++)
      step("pre_clr_wr", 0, 0, 0, i, $urandom_range(1, MOD - 1), 0, 1);
    step("clr_pulse", 1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++)
      step("clr_read", 0, 1, 0, 0, 0, i, 0);
    step("clr_tail", 0, 1, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
